// File: rtl/vga_pkg.sv
// Shared VGA constants, player-position FSM states and the per-axis move rule.
// Build option: define PLAYER_WRAP_EN to wrap at the screen edges instead of clamping.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  localparam logic [10:0] XMAX    = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] YMAX    = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] START_X = 11'd312;
  localparam logic [10:0] START_Y = 11'd232;
  localparam logic [10:0] STEP    = 11'd2;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} pos_state_t;

  // One axis: inc/dec held together cancel; 11-bit math never overflows.
  function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic inc,
                                            input logic dec, input logic [10:0] max_pos);
    logic [10:0] r;
    r = pos;
    if (inc && !dec) begin
      if (pos + STEP > max_pos)
`ifdef PLAYER_WRAP_EN
        r = pos + STEP - (max_pos + 11'd1);
`else
        r = max_pos;
`endif
      else
        r = pos + STEP;
    end else if (dec && !inc) begin
      if (pos < STEP)
`ifdef PLAYER_WRAP_EN
        r = pos + (max_pos + 11'd1) - STEP;
`else
        r = 11'd0;
`endif
      else
        r = pos - STEP;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser plus a counter that accepts a level
// change only after DEB_CYCLES consecutive cycles of the new level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_50,
  input  logic n_reset,
  input  logic btn_n,
  output logic held
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    if (~sync2_q == held_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      held_d = ~held_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_50 or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held = held_q;

endmodule

// File: rtl/player_pos_ctrl.sv
// Debounced buttons move the sprite by STEP pixels once per frame (v_sync falling edge).
// Build option: PLAYER_WRAP_EN selects edge wrap instead of clamping.
module player_pos_ctrl
  import vga_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk_50,
  input  logic       n_reset,
  input  logic       v_sync,
  input  logic [3:0] btn_n,
  output logic [9:0] player_x,
  output logic [8:0] player_y,
  output logic       frame_tick,
  output logic [3:0] btn_held
);

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_50  (clk_50),
      .n_reset (n_reset),
      .btn_n   (btn_n[i]),
      .held    (btn_held[i])
    );
  end

  logic       vs_s1_q, vs_s2_q, vs_prev_q;
  logic       frame_tick_q, frame_tick_d;
  pos_state_t state_q, state_d;
  logic [3:0] btn_q, btn_d;
  logic [9:0] next_x_q, next_x_d, player_x_q, player_x_d;
  logic [8:0] next_y_q, next_y_d, player_y_q, player_y_d;

  always_comb begin
    frame_tick_d = vs_prev_q & ~vs_s2_q;
    state_d      = state_q;
    btn_d        = btn_q;
    next_x_d     = next_x_q;
    next_y_d     = next_y_q;
    player_x_d   = player_x_q;
    player_y_d   = player_y_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_q) begin
          btn_d   = btn_held;
          state_d = CALC;
        end
      end
      CALC: begin
        next_x_d = 10'(step_axis({1'b0, player_x_q}, btn_q[BTN_RIGHT], btn_q[BTN_LEFT], XMAX));
        next_y_d = 9'(step_axis({2'b00, player_y_q}, btn_q[BTN_DOWN], btn_q[BTN_UP], YMAX));
        state_d  = COMMIT;
      end
      COMMIT: begin
        // Both axes load on one edge so the renderer never sees a half-update.
        player_x_d = next_x_q;
        player_y_d = next_y_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge n_reset) begin
    if (!n_reset) begin
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      state_q      <= IDLE;
      btn_q        <= '0;
      next_x_q     <= START_X[9:0];
      next_y_q     <= START_Y[8:0];
      player_x_q   <= START_X[9:0];
      player_y_q   <= START_Y[8:0];
    end else begin
      vs_s1_q      <= v_sync;
      vs_s2_q      <= vs_s1_q;
      vs_prev_q    <= vs_s2_q;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      btn_q        <= btn_d;
      next_x_q     <= next_x_d;
      next_y_q     <= next_y_d;
      player_x_q   <= player_x_d;
      player_y_q   <= player_y_d;
    end
  end

  assign player_x   = player_x_q;
  assign player_y   = player_y_q;
  assign frame_tick = frame_tick_q;

endmodule
